// File: rtl/decoder_reg_onehot_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
// Holds the mode and state encodings plus a width helper.
package decoder_pkg;

  typedef enum logic {
    MODE_LATCH = 1'b0,
    MODE_PULSE = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_e;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decoder_reg_onehot_dec.sv
// Combinational binary-to-one-hot decode with an in-range flag.
// Codes at or above NUM_OUT produce an all-zero vector and in_range=0.
module onehot_dec #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot,
  output logic               in_range
);

  always_comb begin
    onehot   = '0;
    in_range = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (sel == SEL_W'(i)) begin
        onehot[i] = 1'b1;
        in_range  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_reg_onehot.sv
// Registered one-hot decoder with LATCH/PULSE output modes and valid/ready intake.
// The decoded vector is registered, so sel never reaches d combinationally.
module decoder_reg_onehot
  import decoder_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int NUM_OUT   = 4,
  parameter int PULSE_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] d,
  output logic               d_valid,
  output logic               busy,
  output logic               err,
  input  logic               err_clr
);

  localparam int                CNT_W    = width_of(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  logic [NUM_OUT-1:0] dec_onehot;
  logic               dec_in_range;

  state_e             state_p1, state_nx;
  mode_e              mode_p1, mode_nx;
  logic [CNT_W-1:0]   cnt_p1, cnt_nx;
  logic [NUM_OUT-1:0] d_p1, d_nx;
  logic               dv_p1;
  logic               err_p1, err_nx;
  logic               accept;

  onehot_dec #(
    .SEL_W  (SEL_W),
    .NUM_OUT(NUM_OUT)
  ) u_dec (
    .sel     (sel),
    .onehot  (dec_onehot),
    .in_range(dec_in_range)
  );

  assign in_ready = (state_p1 == ST_IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nx = state_p1;
    mode_nx  = mode_p1;
    cnt_nx   = cnt_p1;
    d_nx     = d_p1;
    // An out-of-range acceptance below overrides a coincident clear.
    err_nx   = err_p1 & ~err_clr;
    case (state_p1)
      ST_IDLE: begin
        if (accept) begin
          mode_nx = mode_e'(mode);
          if (!dec_in_range) begin
            d_nx   = '0;
            err_nx = 1'b1;
          end else begin
            d_nx = dec_onehot;
            if (mode_e'(mode) == MODE_PULSE) begin
              state_nx = ST_PULSE;
              cnt_nx   = CNT_LOAD;
            end
          end
        end
      end
      ST_PULSE: begin
        if (cnt_p1 == '0) begin
          d_nx     = '0;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt_p1 - CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // ---- stage p1: registered outputs and control state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ST_IDLE;
      mode_p1  <= MODE_LATCH;
      cnt_p1   <= '0;
      d_p1     <= '0;
      dv_p1    <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      state_p1 <= state_nx;
      mode_p1  <= mode_nx;
      cnt_p1   <= cnt_nx;
      d_p1     <= d_nx;
      dv_p1    <= |d_nx;
      err_p1   <= err_nx;
    end
  end

  assign d       = d_p1;
  assign d_valid = dv_p1;
  assign busy    = (state_p1 == ST_PULSE);
  assign err     = err_p1;

endmodule

// File: tb/tb_decoder_reg_onehot.sv
// Bench for decoder_reg_onehot: four parameterisations share clk/rst and are
// checked every cycle against a pulse-countdown reference model.
module tb_decoder_reg_onehot;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u0: SEL_W=2 NUM_OUT=4 PULSE_LEN=4
  logic mode0, vld0, clr0, rdy0, dv0, busy0, err0;
  logic [1:0] sel0;
  logic [3:0] d0;
  // u1: SEL_W=2 NUM_OUT=3 PULSE_LEN=8
  logic mode1, vld1, clr1, rdy1, dv1, busy1, err1;
  logic [1:0] sel1;
  logic [2:0] d1;
  // u2: SEL_W=2 NUM_OUT=4 PULSE_LEN=1
  logic mode2, vld2, clr2, rdy2, dv2, busy2, err2;
  logic [1:0] sel2;
  logic [3:0] d2;
  // u3: SEL_W=3 NUM_OUT=8 PULSE_LEN=4
  logic mode3, vld3, clr3, rdy3, dv3, busy3, err3;
  logic [2:0] sel3;
  logic [7:0] d3;

  decoder_reg_onehot #(.SEL_W(2), .NUM_OUT(4), .PULSE_LEN(4)) u0 (
    .clk(clk), .rst(rst), .mode(mode0), .in_valid(vld0), .in_ready(rdy0), .sel(sel0),
    .d(d0), .d_valid(dv0), .busy(busy0), .err(err0), .err_clr(clr0));
  decoder_reg_onehot #(.SEL_W(2), .NUM_OUT(3), .PULSE_LEN(8)) u1 (
    .clk(clk), .rst(rst), .mode(mode1), .in_valid(vld1), .in_ready(rdy1), .sel(sel1),
    .d(d1), .d_valid(dv1), .busy(busy1), .err(err1), .err_clr(clr1));
  decoder_reg_onehot #(.SEL_W(2), .NUM_OUT(4), .PULSE_LEN(1)) u2 (
    .clk(clk), .rst(rst), .mode(mode2), .in_valid(vld2), .in_ready(rdy2), .sel(sel2),
    .d(d2), .d_valid(dv2), .busy(busy2), .err(err2), .err_clr(clr2));
  decoder_reg_onehot #(.SEL_W(3), .NUM_OUT(8), .PULSE_LEN(4)) u3 (
    .clk(clk), .rst(rst), .mode(mode3), .in_valid(vld3), .in_ready(rdy3), .sel(sel3),
    .d(d3), .d_valid(dv3), .busy(busy3), .err(err3), .err_clr(clr3));

  int total = 0;
  int bad   = 0;

  // Reference: which output is shown (-1 = none) and how many strobe cycles remain.
  typedef struct {
    int disp;
    int rem;
    bit err;
  } mstate_t;

  mstate_t ms0, ms1, ms2, ms3;

  function automatic mstate_t mstep(mstate_t s, logic r, logic v, int sel, logic md,
                                    logic clr, int n, int pl);
    mstate_t t = s;
    bit oor = 1'b0;
    if (r) begin
      t.disp = -1;
      t.rem  = 0;
      t.err  = 1'b0;
      return t;
    end
    if (s.rem > 0) begin
      t.rem = s.rem - 1;
      if (t.rem == 0) t.disp = -1;
    end else if (v) begin
      if (sel >= n) begin
        t.disp = -1;
        oor    = 1'b1;
      end else begin
        t.disp = sel;
        t.rem  = md ? pl : 0;
      end
    end
    t.err = oor ? 1'b1 : (clr ? 1'b0 : s.err);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_unit(input string tag, input mstate_t m, input logic [7:0] d,
                          input logic dv, input logic bsy, input logic rdy, input logic er);
    logic [7:0] ed;
    ed = (m.disp >= 0) ? 8'(1 << m.disp) : 8'h00;
    chk({tag, ".d"}, 32'(d), 32'(ed));
    chk({tag, ".d_valid"}, 32'(dv), 32'(ed != 8'h00));
    chk({tag, ".busy"}, 32'(bsy), 32'(m.rem > 0));
    chk({tag, ".in_ready"}, 32'(rdy), 32'(m.rem == 0));
    chk({tag, ".err"}, 32'(er), 32'(m.err));
    chk({tag, ".onehot"}, 32'($countones(d) <= 1), 32'd1);
  endtask

  // Advance one clock: step the models on the inputs present at the edge, then check.
  task automatic tick();
    ms0 = mstep(ms0, rst, vld0, int'(sel0), mode0, clr0, 4, 4);
    ms1 = mstep(ms1, rst, vld1, int'(sel1), mode1, clr1, 3, 8);
    ms2 = mstep(ms2, rst, vld2, int'(sel2), mode2, clr2, 4, 1);
    ms3 = mstep(ms3, rst, vld3, int'(sel3), mode3, clr3, 8, 4);
    @(posedge clk);
    #1;
    chk_unit("u0", ms0, 8'(d0), dv0, busy0, rdy0, err0);
    chk_unit("u1", ms1, 8'(d1), dv1, busy1, rdy1, err1);
    chk_unit("u2", ms2, 8'(d2), dv2, busy2, rdy2, err2);
    chk_unit("u3", ms3, d3, dv3, busy3, rdy3, err3);
  endtask

  typedef struct {
    logic       mode;
    logic       vld;
    logic [1:0] sel;
    logic [3:0] exp_d;
    logic       exp_rdy;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 2'd1, 4'b0010, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 2'd3, 4'b1000, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 4'b1000, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 2'd1, 4'b0010, 1'b1};

    ms0 = '{-1, 0, 1'b0};
    ms1 = ms0;
    ms2 = ms0;
    ms3 = ms0;
    rst = 1'b1;
    {mode0, vld0, clr0, sel0} = '0;
    {mode1, vld1, clr1, sel1} = '0;
    {mode2, vld2, clr2, sel2} = '0;
    {mode3, vld3, clr3, sel3} = '0;

    // Reset state
    tick();
    tick();
    chk("reset_d", 32'(d0), 32'h0);
    chk("reset_ready", 32'(rdy0), 32'h1);
    chk("reset_busy", 32'(busy0), 32'h0);
    chk("reset_err", 32'(err0), 32'h0);
    rst = 1'b0;

    // LATCH table on u0
    for (int i = 0; i < 6; i++) begin
      mode0 = tbl[i].mode;
      vld0  = tbl[i].vld;
      sel0  = tbl[i].sel;
      tick();
      chk("latch_d", 32'(d0), 32'(tbl[i].exp_d));
      chk("latch_ready", 32'(rdy0), 32'(tbl[i].exp_rdy));
      chk("latch_dvalid", 32'(dv0), 32'h1);
    end

    // PULSE timing on u0; a request held during the strobe waits for the clear
    mode0 = 1'b1; vld0 = 1'b1; sel0 = 2'd2;
    tick();
    chk("pulse_d1", 32'(d0), 32'h4);
    mode0 = 1'b0; sel0 = 2'd1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("pulse_d", 32'(d0), 32'h4);
      chk("pulse_busy", 32'(busy0), 32'h1);
      chk("pulse_ready", 32'(rdy0), 32'h0);
    end
    tick();
    chk("pulse_clear", 32'(d0), 32'h0);
    chk("pulse_ready_after", 32'(rdy0), 32'h1);
    tick();
    chk("held_accept", 32'(d0), 32'h2);
    vld0 = 1'b0;

    // Out of range on u1 (NUM_OUT=3)
    mode1 = 1'b0; vld1 = 1'b1; sel1 = 2'd3;
    tick();
    chk("oor_d", 32'(d1), 32'h0);
    chk("oor_err", 32'(err1), 32'h1);
    chk("oor_busy", 32'(busy1), 32'h0);
    mode1 = 1'b1; clr1 = 1'b1;
    tick();
    chk("oor_set_over_clr", 32'(err1), 32'h1);
    chk("oor_pulse_busy", 32'(busy1), 32'h0);
    vld1 = 1'b0;
    tick();
    chk("oor_clr", 32'(err1), 32'h0);
    clr1 = 1'b0;

    // Reset mid-pulse on u1 (PULSE_LEN=8), with err set beforehand
    vld1 = 1'b1; sel1 = 2'd3;
    tick();
    sel1 = 2'd1; mode1 = 1'b1;
    tick();
    chk("mid_pulse_d", 32'(d1), 32'h2);
    vld1 = 1'b0;
    tick();
    chk("mid_pulse_err", 32'(err1), 32'h1);
    rst = 1'b1; vld1 = 1'b1; sel1 = 2'd0;
    tick();
    chk("rst_mid_d", 32'(d1), 32'h0);
    chk("rst_mid_busy", 32'(busy1), 32'h0);
    chk("rst_mid_err", 32'(err1), 32'h0);
    rst = 1'b0; vld1 = 1'b0;
    tick();
    chk("rst_mid_ignored", 32'(d1), 32'h0);

    // PULSE_LEN=1 on u2
    mode2 = 1'b1; vld2 = 1'b1; sel2 = 2'd3;
    tick();
    chk("pl1_d", 32'(d2), 32'h8);
    chk("pl1_busy", 32'(busy2), 32'h1);
    vld2 = 1'b0;
    tick();
    chk("pl1_clear", 32'(d2), 32'h0);
    chk("pl1_busy_clear", 32'(busy2), 32'h0);

    // Mode toggling during a strobe on u0 leaves the length unchanged
    mode0 = 1'b1; vld0 = 1'b1; sel0 = 2'd0;
    tick();
    vld0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mode0 = ~mode0;
      tick();
      chk("modeign_d", 32'(d0), 32'h1);
    end
    tick();
    chk("modeign_clear", 32'(d0), 32'h0);

    // Width sweep on u3
    mode3 = 1'b0; vld3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel3 = 3'(i);
      tick();
      chk("sweep_d", 32'(d3), 32'(1 << i));
    end
    vld3 = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      vld0  = ($urandom_range(0, 2) != 0); mode0 = 1'($urandom); sel0 = 2'($urandom);
      clr0  = ($urandom_range(0, 3) == 0);
      vld1  = ($urandom_range(0, 2) != 0); mode1 = 1'($urandom); sel1 = 2'($urandom);
      clr1  = ($urandom_range(0, 3) == 0);
      vld2  = ($urandom_range(0, 2) != 0); mode2 = 1'($urandom); sel2 = 2'($urandom);
      clr2  = ($urandom_range(0, 3) == 0);
      vld3  = ($urandom_range(0, 2) != 0); mode3 = 1'($urandom); sel3 = 3'($urandom);
      clr3  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_reg_onehot.md
Name: decoder_reg_onehot

Overview:
- Parametrised, registered binary-to-one-hot decoder; successor to the fixed 2-to-4 combinational decoder.
- Accepts a select code over a valid/ready handshake and drives a registered one-hot output.
- Two output modes:
  - LATCH: code held until the next accepted code.
  - PULSE: one-hot asserted for PULSE_LEN cycles, then cleared.
- Flags out-of-range codes when NUM_OUT is not a power of two.
- Used for chip-select/strobe generation downstream of control logic.

Parameters:
- SEL_W, 2, select code width (>=1).
- NUM_OUT, 4, number of one-hot outputs; 2 <= NUM_OUT <= 2**SEL_W.
- PULSE_LEN, 4, PULSE-mode strobe length in cycles (>=1).
- CNT_W (localparam), $clog2(PULSE_LEN+1), pulse counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous active-high reset.
- mode  input  1  0 = LATCH, 1 = PULSE; sampled only on acceptance.
- in_valid  input  1  sel is valid this cycle.
- in_ready  output  1  block can accept sel this cycle.
- sel  input  SEL_W  binary select code.
- d  output  NUM_OUT  registered one-hot output; all zero when idle or invalid.
- d_valid  output  1  high while d is non-zero.
- busy  output  1  PULSE strobe in progress.
- err  output  1  sticky flag: an out-of-range code was accepted.
- err_clr  input  1  clears err.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: d=0, d_valid=0, busy=0, err=0, state IDLE, counter 0. in_ready=1 in the cycle after reset.
- Acceptance occurs on a clk edge with in_valid && in_ready. mode is latched into an internal mode register at that edge.
- Latency: code accepted at edge k -> d reflects it immediately after edge k, i.e. one registered stage. No combinational path from sel to d.
- Decode rule: d[i]=1 iff sel==i and sel<NUM_OUT. At most one bit of d is ever set.
- Out-of-range (sel>=NUM_OUT) handling:
  - Handshake completes; d cleared to 0; err set.
  - No pulse started; state returns or stays IDLE.
- States:
  - IDLE: d=0 or a latched code in LATCH mode. in_ready=1.
  - PULSE: busy=1, in_ready=0. Counter loads PULSE_LEN-1 on entry and decrements each edge. When the counter is 0 at an edge, d<=0 and the state goes to IDLE.
- LATCH-mode acceptance: d updated, state IDLE. in_ready stays 1, so back-to-back codes update d every cycle.
- PULSE-mode acceptance (in range): d set, enter PULSE. d is high for exactly PULSE_LEN cycles. The first acceptance opportunity is the cycle after d clears.
- PULSE_LEN=1: d high exactly one cycle; busy high that same cycle.
- A LATCH acceptance while a latched code is displayed replaces it. A PULSE acceptance while a latched code is displayed replaces it and starts the pulse.
- Mode changes while busy are ignored until the next acceptance.
- d_valid = |d, registered alongside d.
- err priority: set > clear when an out-of-range acceptance and err_clr coincide. Otherwise err_clr clears err at the edge.
- rst mid-pulse aborts immediately: all outputs reach reset values at that edge, and in_valid in the same cycle is ignored.
- Counter never wraps; it saturates at 0 only in IDLE.

Decomposition:
- Shared package decoder_pkg holds:
  - mode encodings MODE_LATCH=1'b0, MODE_PULSE=1'b1;
  - state encoding ST_IDLE, ST_PULSE;
  - a clog2-style width helper.
- One natural sub-module: onehot_dec, purely combinational, sel -> one-hot with an in-range flag, parametrised SEL_W/NUM_OUT. It is instantiated once and registered in the top.
- Top holds the FSM, counter, handshake and err logic.

Test Plan:
- Reset then LATCH codes:
  - Stimulus: rst high 2 cycles; then mode=0, in_valid=1, sel=0,1,2,3 on consecutive cycles (defaults).
  - Response: d=0001,0010,0100,1000 one cycle after each; in_ready always 1; d_valid=1.
- PULSE timing:
  - Stimulus: mode=1, sel=2, one in_valid cycle, PULSE_LEN=4.
  - Response: d=0100 and busy=1 for exactly 4 cycles, then d=0; in_ready=0 during those 4 cycles.
  - Follow-up: an in_valid held during the pulse is accepted only in the first cycle after clear.
- Out of range:
  - Stimulus: NUM_OUT=3, SEL_W=2, sel=3 accepted in either mode.
  - Response: d=000, err=1, busy=0.
  - Follow-up: err_clr and a second sel=3 in the same cycle -> err stays 1; err_clr alone -> err=0 next cycle.
- Reset mid-pulse:
  - Stimulus: PULSE_LEN=8, sel=1, mode=1; assert rst on the 3rd pulse cycle together with in_valid, sel=0.
  - Response: d=0, busy=0, err=0 after that edge; sel=0 not accepted.
- PULSE_LEN=1 and mode ignore:
  - Stimulus: PULSE_LEN=1, sel=3, mode=1.
  - Response: d=1000 for one cycle.
  - Follow-up: with PULSE_LEN=4, toggling mode during busy does not shorten or extend the pulse.
- Width sweep:
  - Stimulus: SEL_W=3, NUM_OUT=8, all codes 0..7 in LATCH mode.
  - Response: each d equals 1<<sel; never more than one bit set, checked every cycle.
